// File: rtl/fetch_buffer.sv
// In-order FIFO of {pc, instr} pairs decoupling fetch from decode.
// Supports single-cycle flush, freeze-held head, and a sticky overflow flag.
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     ihit,
  input  logic [WORD_W-1:0]        fetch_pc,
  input  logic [WORD_W-1:0]        fetch_instr,
  input  logic                     flush,
  input  logic                     freeze,
  output logic                     full,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [WORD_W-1:0]        dec_pc,
  output logic [WORD_W-1:0]        dec_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_pc    [DEPTH];
  logic [WORD_W-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Status comes from the registered count only, so a same-cycle pop never frees a slot.
  assign full      = (count == CNT_W'(DEPTH));
  assign dec_valid = (count != '0);

  always_comb begin
    push = ihit & ~full & ~flush;
    pop  = dec_valid & dec_ready & ~freeze & ~flush;
  end

  assign dec_pc    = dec_valid ? mem_pc[rd_ptr]    : '0;
  assign dec_instr = dec_valid ? mem_instr[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (ihit && full) overflow <= 1'b1;
    end
  end

  // Storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge CLK) begin
    if (nRST && push) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_instr[wr_ptr] <= fetch_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;

  typedef struct {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } entry_t;

  logic              CLK;
  logic              nRST;
  logic              ihit;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] fetch_instr;
  logic              flush;
  logic              freeze;
  logic              full;
  logic              dec_valid;
  logic              dec_ready;
  logic [WORD_W-1:0] dec_pc;
  logic [WORD_W-1:0] dec_instr;
  logic [2:0]        count;
  logic              overflow;

  entry_t modelQ[$];
  bit     modelOvf;
  bit     checkEn;
  int     nCompared;
  int     nMismatched;

  fetch_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .flush(flush), .freeze(freeze), .full(full),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_instr(dec_instr), .count(count), .overflow(overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue evaluated on the inputs seen at the edge.
  task automatic modelUpdate();
    bit wasFull;
    bit doPop;
    bit doPush;
    entry_t e;
    if (!nRST) begin
      modelQ.delete();
      modelOvf = 0;
    end else if (flush) begin
      modelQ.delete();
    end else begin
      wasFull = (modelQ.size() == DEPTH);
      doPop   = (modelQ.size() != 0) && dec_ready && !freeze;
      doPush  = ihit && !wasFull;
      if (ihit && wasFull) modelOvf = 1;
      if (doPop) void'(modelQ.pop_front());
      if (doPush) begin
        e.pc    = fetch_pc;
        e.instr = fetch_instr;
        modelQ.push_back(e);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then advance the model past the rising edge.
  task automatic applyStimulus(input bit rstN, input bit hit, input logic [31:0] pc,
                               input logic [31:0] instr, input bit fl, input bit frz,
                               input bit rdy);
    @(negedge CLK);
    nRST        = rstN;
    ihit        = hit;
    fetch_pc    = pc;
    fetch_instr = instr;
    flush       = fl;
    freeze      = frz;
    dec_ready   = rdy;
    @(posedge CLK);
    modelUpdate();
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkEn = 1;
  endtask

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("cmp_count", {29'd0, count}, modelQ.size());
      checkOutput("cmp_full", {31'd0, full}, (modelQ.size() == DEPTH) ? 1 : 0);
      checkOutput("cmp_dec_valid", {31'd0, dec_valid}, (modelQ.size() != 0) ? 1 : 0);
      checkOutput("cmp_dec_pc", dec_pc, (modelQ.size() != 0) ? modelQ[0].pc : 32'd0);
      checkOutput("cmp_dec_instr", dec_instr, (modelQ.size() != 0) ? modelQ[0].instr : 32'd0);
      checkOutput("cmp_overflow", {31'd0, overflow}, {31'd0, modelOvf});
    end
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    checkEn     = 0;
    modelOvf    = 0;
    nRST = 0; ihit = 0; fetch_pc = 0; fetch_instr = 0;
    flush = 0; freeze = 0; dec_ready = 0;

    // Reset state
    doReset();
    checkOutput("rst_count", {29'd0, count}, 0);
    checkOutput("rst_dec_valid", {31'd0, dec_valid}, 0);
    checkOutput("rst_dec_pc", dec_pc, 0);
    checkOutput("rst_dec_instr", dec_instr, 0);
    checkOutput("rst_full", {31'd0, full}, 0);
    checkOutput("rst_overflow", {31'd0, overflow}, 0);

    // Single push visible right after the edge
    applyStimulus(1, 1, 32'h1000, 32'hACE1ACE1, 0, 0, 0);
    checkOutput("single_valid", {31'd0, dec_valid}, 1);
    checkOutput("single_pc", dec_pc, 32'h1000);
    checkOutput("single_instr", dec_instr, 32'hACE1ACE1);
    checkOutput("single_count", {29'd0, count}, 1);

    // Fill, overflow, drain in order
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 4 * i, 32'hA000 + i, 0, 0, 0);
    applyStimulus(1, 1, 32'h10, 32'hBAD, 0, 0, 0);
    checkOutput("fill_full", {31'd0, full}, 1);
    checkOutput("fill_count", {29'd0, count}, 4);
    checkOutput("fill_overflow", {31'd0, overflow}, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_pc", dec_pc, 4 * i);
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("drain_empty", {31'd0, dec_valid}, 0);
    checkOutput("drain_ovf_sticky", {31'd0, overflow}, 1);

    // Streaming across pointer wrap
    doReset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) checkOutput("wrap_head", dec_pc, 4 * (i - 1));
      applyStimulus(1, 1, 4 * i, 32'hC000 + i, 0, 0, 1);
      checkOutput("wrap_count", {29'd0, count}, 1);
    end
    checkOutput("wrap_last", dec_pc, 32'h24);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("wrap_no_ovf", {31'd0, overflow}, 0);

    // Flush beats a simultaneous push and pop
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h3000 + 4 * i, i, 0, 0, 0);
    applyStimulus(1, 1, 32'hDEADBEEF, 32'h1, 1, 0, 1);
    checkOutput("flush_count", {29'd0, count}, 0);
    checkOutput("flush_valid", {31'd0, dec_valid}, 0);
    applyStimulus(1, 1, 32'hABCDEF01, 32'h55, 0, 0, 0);
    checkOutput("flush_next_pc", dec_pc, 32'hABCDEF01);
    checkOutput("flush_next_count", {29'd0, count}, 1);

    // Freeze holds the head while pushes continue
    doReset();
    applyStimulus(1, 1, 32'h2000, 32'h20, 0, 0, 0);
    applyStimulus(1, 1, 32'h2004, 32'h24, 0, 0, 0);
    applyStimulus(1, 1, 32'h4000, 32'h40, 0, 1, 1);
    applyStimulus(1, 1, 32'h4000, 32'h41, 0, 1, 1);
    checkOutput("freeze_head", dec_pc, 32'h2000);
    checkOutput("freeze_count", {29'd0, count}, 4);
    checkOutput("freeze_full", {31'd0, full}, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("unfreeze_pc1", dec_pc, 32'h2004);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("unfreeze_pc2", dec_pc, 32'h4000);
    checkOutput("unfreeze_instr2", dec_instr, 32'h40);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 3) != 0),
                    $urandom, $urandom,
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) != 0));
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
